// File: rtl/tick_serial_tx_pkg.sv
// rtl/tick_serial_tx_pkg.sv - shared state encoding and sizing helpers for the serial transmitter
package tick_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_SHIFT = 2'b10,
    ST_STOP  = 2'b11
  } state_e;

  localparam logic SOUT_IDLE = 1'b1;
  localparam logic SOUT_START = 1'b0;
  localparam logic SOUT_STOP = 1'b1;

  // Index width for a WIDTH-bit frame; at least one bit so WIDTH=1 still elaborates.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/dflipflop.sv
// rtl/dflipflop.sv - single D flip-flop with synchronous active-high reset to a chosen value
module dflipflop #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_in,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset_in) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, LSB-first shift register feeding the serial line
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_lsb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = sr_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_lsb = sr_q[0];

endmodule

// File: rtl/tick_serial_tx.sv
// rtl/tick_serial_tx.sv - tick-paced serial transmitter: start bit, WIDTH data bits LSB first, stop bit
module tick_serial_tx
  import tick_serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             tick,
  output logic             tick_clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             tx_done
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  logic [1:0]    state_bits_q;
  logic [1:0]    state_bits_d;
  state_e        state_q;
  state_e        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          sout_q;
  logic          sout_d;
  logic          ready_q;
  logic          ready_d;
  logic          tx_done_q;
  logic          tx_done_d;
  logic          tick_clr_q;
  logic          tick_clr_d;
  logic          load;
  logic          shift;
  logic          q_lsb;
  logic          tick_ok;
  logic          accept;

  for (genvar i = 0; i < 2; i++) begin : g_state_ff
    dflipflop #(.RST_VAL(1'b0)) u_state_ff (
      .clk      (clk),
      .reset_in (reset_in),
      .d        (state_bits_d[i]),
      .q        (state_bits_q[i])
    );
  end

  assign state_q      = state_e'(state_bits_q);
  assign state_bits_d = state_d;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .reset_in (reset_in),
    .load     (load),
    .shift    (shift),
    .d        (data_in),
    .q_lsb    (q_lsb)
  );

  // The tick seen while the upstream counter is being cleared is stale timing.
  assign tick_ok = tick & ~tick_clr_q;
  assign accept  = valid & ready_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sout_d     = sout_q;
    tx_done_d  = 1'b0;
    tick_clr_d = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sout_d = SOUT_IDLE;
        if (accept) begin
          load       = 1'b1;
          idx_d      = '0;
          state_d    = ST_START;
          sout_d     = SOUT_START;
          tick_clr_d = 1'b1;
        end
      end
      ST_START: begin
        if (tick_ok) begin
          state_d = ST_SHIFT;
          sout_d  = q_lsb;
          shift   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick_ok) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
            sout_d  = SOUT_STOP;
          end else begin
            idx_d  = idx_q + IW'(1);
            sout_d = q_lsb;
            shift  = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick_ok) begin
          state_d   = ST_IDLE;
          sout_d    = SOUT_IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sout_d  = SOUT_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      idx_q      <= '0;
      sout_q     <= SOUT_IDLE;
      ready_q    <= 1'b1;
      tx_done_q  <= 1'b0;
      tick_clr_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      sout_q     <= sout_d;
      ready_q    <= ready_d;
      tx_done_q  <= tx_done_d;
      tick_clr_q <= tick_clr_d;
    end
  end

  assign sout     = sout_q;
  assign ready    = ready_q;
  assign tx_done  = tx_done_q;
  assign tick_clr = tick_clr_q;

endmodule

// File: tb/tb_tick_serial_tx.sv
// tb/tb_tick_serial_tx.sv - scoreboard bench for tick_serial_tx with a period-4 upstream tick counter
module tb_tick_serial_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_in = 1'b1;
  logic         tick;
  logic         tick_clr;
  logic [W-1:0] data_in = '0;
  logic         valid = 1'b0;
  logic         ready;
  logic         sout;
  logic         tx_done;
  logic         extra_tick = 1'b0;
  logic [1:0]   cnt_q = 2'd0;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];
  int   mon_n = 0;
  bit   mon_in_frame = 0;
  bit   mon_pending = 0;
  bit   mon_ready_seen = 0;

  tick_serial_tx #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .tick     (tick),
    .tick_clr (tick_clr),
    .data_in  (data_in),
    .valid    (valid),
    .ready    (ready),
    .sout     (sout),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_in || tick_clr) cnt_q <= 2'd0;
    else cnt_q <= cnt_q + 2'd1;
  end

  assign tick = (cnt_q == 2'd3) | extra_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name);
    logic e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got sout %0b expected nothing (scoreboard empty) at %0t", name, sout, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, sout, e);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
  endtask

  // Monitor: one sample per bit period, the cycle after each tick the DUT should honour.
  always @(negedge clk) begin
    bit done_now;
    done_now = 0;
    if (reset_in) begin
      exp_q.delete();
      mon_in_frame = 0;
      mon_pending = 0;
    end else begin
      if (mon_pending) begin
        mon_pending = 0;
        mon_n++;
        if (mon_n < W + 2) begin
          pop_check($sformatf("sout_bit%0d", mon_n));
        end else begin
          done_now = 1;
          check("tx_done_at_frame_end", tx_done, 1'b1);
          check("ready_low_in_frame", mon_ready_seen, 1'b0);
          mon_in_frame = 0;
        end
      end
      if (tx_done && !done_now) begin
        miscompares++;
        $display("FAIL spurious_tx_done: got 1 expected 0 at %0t", $time);
      end
      if (tick_clr) begin
        if (mon_in_frame) begin
          miscompares++;
          $display("FAIL tick_clr_in_frame: got 1 expected 0 at %0t", $time);
        end
        mon_in_frame = 1;
        mon_n = 0;
        mon_ready_seen = 0;
        pop_check("sout_start");
      end else if (mon_in_frame && ready) begin
        mon_ready_seen = 1;
      end
      mon_pending = mon_in_frame && tick && !tick_clr;
    end
  end

  task automatic send(input logic [W-1:0] d, input bit hold, input bit collide, input bit b2b);
    int g;
    g = 0;
    @(posedge clk); #1;
    valid = 1'b1;
    data_in = d;
    while (!ready && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 400) begin
      miscompares++;
      $display("FAIL accept_timeout: got ready 0 expected 1 at %0t", $time);
    end
    if (b2b) check("b2b_accept_in_done_cycle", tx_done, 1'b1);
    push_frame(d);
    if (collide) extra_tick = 1'b1;
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
    if (collide) begin
      @(posedge clk); #1;
      extra_tick = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!(exp_q.size() == 0 && !mon_in_frame && ready) && g < 1000);
    if (g >= 1000) begin
      miscompares++;
      $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
    end
  endtask

  initial begin
    int g;
    reset_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sout", sout, 1'b1);
    check("reset_ready", ready, 1'b1);
    check("reset_tx_done", tx_done, 1'b0);
    check("reset_tick_clr", tick_clr, 1'b0);
    reset_in = 1'b0;

    send(8'hA5, 0, 0, 0);
    wait_idle();

    send(8'h00, 1, 0, 0);
    send(8'hFF, 0, 0, 1);
    wait_idle();

    send(8'hA5, 0, 0, 0);
    repeat (14) @(posedge clk);
    #1;
    valid = 1'b1;
    data_in = 8'h3C;
    repeat (10) @(posedge clk);
    #1;
    valid = 1'b0;
    wait_idle();

    send(8'hC3, 0, 1, 0);
    wait_idle();

    send(8'hA5, 0, 0, 0);
    g = 0;
    while (mon_n != 4 && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 400) begin
      miscompares++;
      $display("FAIL reach_bit3_timeout: got bit %0d expected 4 at %0t", mon_n, $time);
    end
    reset_in = 1'b1;
    valid = 1'b1;
    data_in = 8'h3C;
    extra_tick = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    valid = 1'b0;
    extra_tick = 1'b0;
    check("midreset_sout", sout, 1'b1);
    check("midreset_ready", ready, 1'b1);
    check("midreset_tx_done", tx_done, 1'b0);
    check("midreset_tick_clr", tick_clr, 1'b0);
    repeat (3) @(posedge clk);
    send(8'h81, 0, 0, 0);
    wait_idle();

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
